command_encoder: RTL and testbench
==================================

Name: command_encoder

Overview:
- Inverse of the instruction decode path: accepts instruction fields (format, opcodes, register numbers, immediate) over a valid/ready handshake and packs them into 16-bit COMMAND words.
- Each word is checked for legality, buffered in a small FIFO, and emitted with a sequential instruction-memory address.
- Sits between the boot/test loader and instruction-memory write port, so programs can be built from fields instead of pre-assembled hex.

Parameters:
- DEPTH, 4, FIFO entries (power of two, ≥2)
- ADDR_W, 8, instruction-memory address width

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous active-high reset
- in_valid  in  1  field set valid
- in_ready  out  1  encoder accepts field set this cycle
- fmt  in  2  instruction class: 00 LD, 01 ST, 10 immediate/branch, 11 ALU/IO
- f_op2  in  3  op2 field (class 10), ignored otherwise
- f_ra  in  3  Ra / Rs register
- f_rb  in  3  Rb / Rd register, or branch condition
- f_op3  in  4  ALU op3 (class 11)
- f_imm  in  8  displacement/immediate; only [3:0] used for class 11
- load_addr  in  1  load start_addr into address counter, clear done
- start_addr  in  ADDR_W  new base address
- out_valid  out  1  encoded word available
- out_ready  in  1  consumer takes word
- out_cmd  out  16  encoded COMMAND
- out_addr  out  ADDR_W  memory address of out_cmd
- err  out  1  one-cycle pulse: illegal field set dropped
- err_count  out  8  saturating count of dropped sets
- done  out  1  HLT has been emitted

Behaviour:
- Reset (async, rst=1): FIFO empty; addr counter = 0; out_valid=0, out_cmd=0, out_addr=0, err=0, err_count=0, done=0.
- Handshake:
  - in_ready = !full && !halt_seen.
  - Transfer occurs when in_valid && in_ready.
  - No combinational path from out_ready to in_ready; a full FIFO refuses input even if popped in the same cycle.
- Encoding, all classes: cmd[15:14] = fmt.
  - LD/ST: [13:11]=f_ra, [10:8]=f_rb, [7:0]=f_imm.
  - Class 10: [13:11]=f_op2, [10:8]=f_rb, [7:0]=f_imm.
    - Legal f_op2: 000 LI, 001 ADDI, 100 B, 111 BE.
    - For B, [10:8] is forced to 000.
  - Class 11: [13:11]=f_ra, [10:8]=f_rb, [7:4]=f_op3.
    - Legal f_op3: 0000–0110, 1000–1011, 1100 IN, 1101 OUT, 1111 HLT.
    - [3:0] = f_imm[3:0] for shifts (1000–1011); otherwise 0000.
- Illegal set (class 10 op2 ∉ legal, or class 11 op3 ∈ {0111, 1110}):
  - Still transferred (handshake completes) but not written to the FIFO.
  - err=1 on the following cycle; err_count increments, saturating at 255.
- Legal set: encoded word written to FIFO in the transfer cycle.
  - Visible at the head with out_valid=1 on the next cycle at the earliest (1-cycle latency when empty).
- Output side:
  - out_cmd/out_addr reflect the FIFO head and are held stable while out_valid && !out_ready.
  - out_addr = address counter.
  - On each pop (out_valid && out_ready), the counter increments modulo 2^ADDR_W (wraps 0xFF→0x00 at default).
- Simultaneous push and pop: occupancy unchanged, both take effect. Pop on empty and push on full are impossible by construction.
- HLT:
  - When a legal HLT set is transferred, halt_seen=1 and in_ready falls the next cycle.
  - When the HLT word pops, done=1.
  - halt_seen and done clear only on load_addr or rst.
- load_addr:
  - Counter ← start_addr; halt_seen, done ← 0.
  - FIFO contents are kept; words still queued take addresses from start_addr onward.
  - If coincident with a pop, the popped word uses the old address and the counter takes start_addr (load wins).
- Reset mid-stream discards all FIFO contents immediately.

Test Plan:
- LD fmt=00, ra=2, rb=5, imm=0x1C → out_cmd=0x151C, out_addr=0x00, out_valid one cycle after transfer.
- ALU SLL fmt=11, ra=1, rb=3, op3=1000, imm=0xA7 → 0xCB87; then ADD with op3=0000, imm=0xFF → [3:0]=0, cmd=0xCB00, out_addr=0x01.
- Illegal op3=0111 → in_ready stays 1, no out_valid, err pulse, err_count=1; following legal word gets the next address without a gap.
- Hold out_ready=0 while sending 5 words with DEPTH=4 → in_ready=0 after the 4th; release → words emerge in order at addresses 0–3, 5th accepted once space exists.
- load_addr with start_addr=0xFE, then emit 3 words → addresses 0xFE, 0xFF, 0x00.
- HLT (fmt=11, op3=1111) → in_ready low next cycle, done=1 after HLT pops; load_addr clears done and restores in_ready; assert rst mid-queue → out_valid=0 immediately.

Source files
------------

// File: rtl/command_encoder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : command_encoder                                                  |
// | Brief   : Packs instruction fields into 16-bit COMMAND words, drops illegal |
// |           sets, buffers legal words and emits them with sequential addrs. |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module command_encoder #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        fmt,
  input  logic [2:0]        f_op2,
  input  logic [2:0]        f_ra,
  input  logic [2:0]        f_rb,
  input  logic [3:0]        f_op3,
  input  logic [7:0]        f_imm,
  input  logic              load_addr,
  input  logic [ADDR_W-1:0] start_addr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [15:0]       out_cmd,
  output logic [ADDR_W-1:0] out_addr,
  output logic              err,
  output logic [7:0]        err_count,
  output logic              done
);

  localparam int                 c_ptr_w      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [c_ptr_w:0]   c_full_count = (c_ptr_w + 1)'(DEPTH);

  logic [15:0]        r_mem [DEPTH];
  logic [c_ptr_w-1:0] r_wr_ptr;
  logic [c_ptr_w-1:0] r_rd_ptr;
  logic [c_ptr_w:0]   r_count;
  logic [ADDR_W-1:0]  r_addr;
  logic               r_halt_seen;
  logic               r_done;
  logic               r_err;
  logic [7:0]         r_err_count;

  logic [15:0]        w_cmd;
  logic               w_legal;
  logic               w_is_hlt;
  logic               w_full;
  logic               w_xfer;
  logic               w_push;
  logic               w_pop;
  logic [15:0]        w_head;
  logic               w_head_is_hlt;

  // Field packing and legality for the incoming set
  always_comb begin
    w_cmd    = {fmt, 14'd0};
    w_legal  = 1'b1;
    w_is_hlt = 1'b0;
    case (fmt)
      2'b00, 2'b01: begin
        w_cmd[13:0] = {f_ra, f_rb, f_imm};
      end
      2'b10: begin
        w_cmd[13:11] = f_op2;
        w_cmd[10:8]  = (f_op2 == 3'b100) ? 3'b000 : f_rb;
        w_cmd[7:0]   = f_imm;
        w_legal      = (f_op2 == 3'b000) || (f_op2 == 3'b001) ||
                       (f_op2 == 3'b100) || (f_op2 == 3'b111);
      end
      default: begin
        w_cmd[13:11] = f_ra;
        w_cmd[10:8]  = f_rb;
        w_cmd[7:4]   = f_op3;
        w_cmd[3:0]   = (f_op3[3:2] == 2'b10) ? f_imm[3:0] : 4'h0;
        w_legal      = (f_op3 != 4'b0111) && (f_op3 != 4'b1110);
        w_is_hlt     = (f_op3 == 4'b1111);
      end
    endcase
  end

  // in_ready depends only on registered state, never on out_ready
  assign w_full   = (r_count == c_full_count);
  assign in_ready = !w_full && !r_halt_seen;
  assign w_xfer   = in_valid && in_ready;
  assign w_push   = w_xfer && w_legal;

  assign out_valid     = (r_count != '0);
  assign w_head        = r_mem[r_rd_ptr];
  assign w_pop         = out_valid && out_ready;
  assign w_head_is_hlt = (w_head[15:14] == 2'b11) && (w_head[7:4] == 4'hF);

  assign out_cmd   = out_valid ? w_head : 16'h0000;
  assign out_addr  = r_addr;
  assign err       = r_err;
  assign err_count = r_err_count;
  assign done      = r_done;

  // Storage array carries no reset; occupancy gates everything visible
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_cmd;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // A load coincident with a pop wins: the popped word keeps the old address
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr      <= '0;
      r_halt_seen <= 1'b0;
      r_done      <= 1'b0;
    end else if (load_addr) begin
      r_addr      <= start_addr;
      r_halt_seen <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      if (w_pop) begin
        r_addr <= r_addr + 1'b1;
      end
      if (w_push && w_is_hlt) begin
        r_halt_seen <= 1'b1;
      end
      if (w_pop && w_head_is_hlt) begin
        r_done <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err       <= 1'b0;
      r_err_count <= 8'h00;
    end else begin
      r_err <= w_xfer && !w_legal;
      if (w_xfer && !w_legal && (r_err_count != 8'hFF)) begin
        r_err_count <= r_err_count + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_command_encoder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_command_encoder                                               |
// | Brief   : Self-checking bench for command_encoder with a queue-based model. |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module tb_command_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  fmt;
  logic [2:0]  f_op2;
  logic [2:0]  f_ra;
  logic [2:0]  f_rb;
  logic [3:0]  f_op3;
  logic [7:0]  f_imm;
  logic        load_addr;
  logic [7:0]  start_addr;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_cmd;
  logic [7:0]  out_addr;
  logic        err;
  logic [7:0]  err_count;
  logic        done;

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] exp_q[$];
  logic [7:0]  exp_addr = 8'h00;
  int          exp_errs = 0;
  logic        exp_done = 1'b0;

  command_encoder #(.DEPTH(4), .ADDR_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .fmt(fmt), .f_op2(f_op2), .f_ra(f_ra), .f_rb(f_rb), .f_op3(f_op3),
    .f_imm(f_imm), .load_addr(load_addr), .start_addr(start_addr),
    .out_valid(out_valid), .out_ready(out_ready), .out_cmd(out_cmd),
    .out_addr(out_addr), .err(err), .err_count(err_count), .done(done)
  );

  always #5 clk = ~clk;

  // Reference encoding written from the instruction-class rules
  function automatic logic [15:0] ref_cmd(input logic [1:0] f, input logic [2:0] op2,
                                          input logic [2:0] ra, input logic [2:0] rb,
                                          input logic [3:0] op3, input logic [7:0] imm);
    int word;
    int lowbits;
    if (f < 2) begin
      word = f * 16384 + ra * 2048 + rb * 256 + imm;
    end else if (f == 2) begin
      word = 2 * 16384 + op2 * 2048 + ((op2 == 4) ? 0 : rb * 256) + imm;
    end else begin
      lowbits = (op3 >= 8 && op3 <= 11) ? (imm % 16) : 0;
      word = 3 * 16384 + ra * 2048 + rb * 256 + op3 * 16 + lowbits;
    end
    return 16'(word);
  endfunction

  function automatic bit ref_legal(input logic [1:0] f, input logic [2:0] op2,
                                   input logic [3:0] op3);
    if (f == 2) return (op2 == 0 || op2 == 1 || op2 == 4 || op2 == 7);
    if (f == 3) return !(op3 == 7 || op3 == 14);
    return 1'b1;
  endfunction

  // Output monitor: every pop is compared against the model queue and address
  always @(negedge clk) begin
    #2;
    if (rst === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL pop_unexpected: out_cmd=%h out_addr=%h, expected no word", out_cmd, out_addr);
      end else if (out_cmd !== exp_q[0] || out_addr !== exp_addr) begin
        n_fail++;
        $display("FAIL pop_word: got cmd=%h addr=%h, expected cmd=%h addr=%h",
                 out_cmd, out_addr, exp_q[0], exp_addr);
      end
      if (exp_q.size() != 0) begin
        if (exp_q[0][15:14] == 2'b11 && exp_q[0][7:4] == 4'hF) exp_done = 1'b1;
        void'(exp_q.pop_front());
      end
      exp_addr = exp_addr + 8'd1;
    end
  end

  task automatic send(input logic [1:0] f, input logic [2:0] op2, input logic [2:0] ra,
                      input logic [2:0] rb, input logic [3:0] op3, input logic [7:0] imm,
                      output bit ok);
    int waited = 0;
    @(negedge clk);
    fmt = f; f_op2 = op2; f_ra = ra; f_rb = rb; f_op3 = op3; f_imm = imm;
    in_valid = 1'b1;
    while (in_ready !== 1'b1 && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (in_ready !== 1'b1) begin
      n_tests++;
      n_fail++;
      $display("FAIL send_timeout: in_ready=%b after %0d cycles, expected 1", in_ready, waited);
      in_valid = 1'b0;
      ok = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    if (ref_legal(f, op2, op3)) exp_q.push_back(ref_cmd(f, op2, ra, rb, op3, imm));
    else if (exp_errs < 255) exp_errs++;
    ok = 1'b1;
  endtask

  task automatic drain();
    int waited = 0;
    @(negedge clk);
    out_ready = 1'b1;
    while (exp_q.size() != 0 && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    @(negedge clk);
    out_ready = 1'b0;
    n_tests++;
    if (exp_q.size() != 0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL drain: out_valid=%b with %0d model words left, expected 0/0", out_valid, exp_q.size());
    end
  endtask

  task automatic do_load(input logic [7:0] a);
    @(negedge clk);
    load_addr = 1'b1;
    start_addr = a;
    @(posedge clk);
    #1;
    load_addr = 1'b0;
    exp_addr = a;
    exp_done = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0; out_ready = 1'b0; load_addr = 1'b0; start_addr = 8'h00;
    fmt = 2'b00; f_op2 = 3'd0; f_ra = 3'd0; f_rb = 3'd0; f_op3 = 4'd0; f_imm = 8'd0;
    repeat (3) @(negedge clk);
    n_tests++;
    if (out_valid !== 1'b0 || out_cmd !== 16'h0 || out_addr !== 8'h0 || err !== 1'b0 ||
        err_count !== 8'h0 || done !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_state: v=%b cmd=%h addr=%h err=%b cnt=%h done=%b rdy=%b, expected 0/0/0/0/0/0/1",
               out_valid, out_cmd, out_addr, err, err_count, done, in_ready);
    end
    rst = 1'b0;
  endtask

  task automatic test_ld();
    bit ok;
    send(2'b00, 3'd0, 3'd2, 3'd5, 4'd0, 8'h1C, ok);
    n_tests++;
    if (out_valid !== 1'b1 || out_cmd !== 16'h151C || out_addr !== 8'h00) begin
      n_fail++;
      $display("FAIL ld_word: v=%b cmd=%h addr=%h, expected 1/151c/00", out_valid, out_cmd, out_addr);
    end
    drain();
  endtask

  task automatic test_alu();
    bit ok;
    do_load(8'h00);
    send(2'b11, 3'd0, 3'd1, 3'd3, 4'b1000, 8'hA7, ok);
    send(2'b11, 3'd0, 3'd1, 3'd3, 4'b0000, 8'hFF, ok);
    n_tests++;
    if (out_cmd !== 16'hCB87 || out_addr !== 8'h00) begin
      n_fail++;
      $display("FAIL alu_sll: cmd=%h addr=%h, expected cb87/00", out_cmd, out_addr);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    #2;
    n_tests++;
    if (out_valid !== 1'b1 || out_cmd !== 16'hCB00 || out_addr !== 8'h01) begin
      n_fail++;
      $display("FAIL alu_add: v=%b cmd=%h addr=%h, expected 1/cb00/01", out_valid, out_cmd, out_addr);
    end
    drain();
  endtask

  task automatic test_illegal();
    bit ok;
    logic [7:0] addr_before;
    addr_before = out_addr;
    send(2'b11, 3'd0, 3'd4, 3'd4, 4'b0111, 8'h00, ok);
    n_tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || err !== 1'b1 || err_count !== 8'd1) begin
      n_fail++;
      $display("FAIL illegal_drop: rdy=%b v=%b err=%b cnt=%0d, expected 1/0/1/1",
               in_ready, out_valid, err, err_count);
    end
    @(posedge clk);
    #1;
    n_tests++;
    if (err !== 1'b0) begin
      n_fail++;
      $display("FAIL illegal_pulse: err=%b one cycle later, expected 0", err);
    end
    send(2'b01, 3'd0, 3'd6, 3'd7, 4'd0, 8'h42, ok);
    n_tests++;
    if (out_cmd !== 16'h7742 || out_addr !== addr_before) begin
      n_fail++;
      $display("FAIL illegal_nogap: cmd=%h addr=%h, expected 7742/%h", out_cmd, out_addr, addr_before);
    end
    drain();
  endtask

  task automatic test_back_to_back();
    bit ok;
    do_load(8'h00);
    for (int i = 0; i < 4; i++) send(2'b00, 3'd0, 3'(i), 3'(i + 1), 4'd0, 8'(8'h10 + i), ok);
    n_tests++;
    if (in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL full_ready: in_ready=%b with 4 queued, expected 0", in_ready);
    end
    fork
      send(2'b10, 3'b100, 3'd0, 3'd5, 4'd0, 8'h99, ok);
      begin
        repeat (3) @(negedge clk);
        out_ready = 1'b1;
      end
    join
    drain();
    n_tests++;
    if (out_addr !== 8'h05) begin
      n_fail++;
      $display("FAIL full_addr: out_addr=%h after 5 words, expected 05", out_addr);
    end
  endtask

  task automatic test_wrap();
    bit ok;
    do_load(8'hFE);
    n_tests++;
    if (out_addr !== 8'hFE) begin
      n_fail++;
      $display("FAIL load_addr: out_addr=%h, expected fe", out_addr);
    end
    send(2'b10, 3'b000, 3'd0, 3'd1, 4'd0, 8'h01, ok);
    send(2'b10, 3'b001, 3'd0, 3'd2, 4'd0, 8'h02, ok);
    send(2'b10, 3'b111, 3'd0, 3'd3, 4'd0, 8'h03, ok);
    drain();
    n_tests++;
    if (out_addr !== 8'h01) begin
      n_fail++;
      $display("FAIL wrap_addr: out_addr=%h after fe,ff,00, expected 01", out_addr);
    end
  endtask

  task automatic test_halt();
    bit ok;
    send(2'b11, 3'd0, 3'd0, 3'd0, 4'b1111, 8'h00, ok);
    n_tests++;
    if (in_ready !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL halt_ready: rdy=%b done=%b, expected 0/0", in_ready, done);
    end
    drain();
    n_tests++;
    if (done !== 1'b1 || exp_done !== 1'b1 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL halt_done: done=%b rdy=%b, expected 1/0", done, in_ready);
    end
    do_load(8'h20);
    n_tests++;
    if (done !== 1'b0 || in_ready !== 1'b1 || out_addr !== 8'h20) begin
      n_fail++;
      $display("FAIL halt_clear: done=%b rdy=%b addr=%h, expected 0/1/20", done, in_ready, out_addr);
    end
  endtask

  task automatic test_random();
    bit prod_done = 1'b0;
    fork
      begin
        bit ok;
        logic [1:0] f;
        logic [2:0] op2;
        logic [3:0] op3;
        bit lg;
        for (int i = 0; i < 40; i++) begin
          f = 2'($urandom);
          op2 = 3'($urandom);
          op3 = 4'($urandom);
          if (op3 == 4'hF) op3 = 4'hC;
          lg = ref_legal(f, op2, op3);
          send(f, op2, 3'($urandom), 3'($urandom), op3, 8'($urandom), ok);
          if (ok) begin
            n_tests++;
            if (err !== !lg || err_count !== 8'(exp_errs)) begin
              n_fail++;
              $display("FAIL rand_err: err=%b cnt=%0d, expected %b/%0d", err, err_count, !lg, exp_errs);
            end
          end
          if ($urandom_range(0, 3) == 0) @(negedge clk);
        end
        prod_done = 1'b1;
      end
      begin
        int cyc = 0;
        while ((!prod_done || exp_q.size() != 0) && cyc < 3000) begin
          @(negedge clk);
          out_ready = 1'($urandom_range(0, 1));
          cyc++;
        end
        out_ready = 1'b0;
      end
    join
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL rand_drain: %0d words never emerged, expected 0", exp_q.size());
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    send(2'b00, 3'd0, 3'd1, 3'd1, 4'd0, 8'h11, ok);
    send(2'b01, 3'd0, 3'd2, 3'd2, 4'd0, 8'h22, ok);
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_tests++;
    if (out_valid !== 1'b0 || out_cmd !== 16'h0 || out_addr !== 8'h0 || err_count !== 8'h0) begin
      n_fail++;
      $display("FAIL reset_mid: v=%b cmd=%h addr=%h cnt=%h, expected 0/0/0/0",
               out_valid, out_cmd, out_addr, err_count);
    end
    exp_q.delete();
    exp_addr = 8'h00;
    exp_errs = 0;
    exp_done = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    send(2'b00, 3'd3, 3'd3, 3'd3, 4'd0, 8'h33, ok);
    drain();
  endtask

  initial begin
    test_reset();
    test_ld();
    test_alu();
    test_illegal();
    test_back_to_back();
    test_wrap();
    test_halt();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1);
  end

endmodule
`default_nettype wire
